// File: rtl/thread_stack_file.sv
// THREADS independent operand stacks sharing one THREADS*DEPTH word array.
// Ops commit at the next posedge and are never stalled; op_ok is registered. top/next/depth read combinationally.
module thread_stack_file #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int THREADS = 2,
  parameter int TIDW    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [TIDW-1:0]            op_tid,
  input  logic [$clog2(DEPTH)-1:0]   op_off,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [TIDW-1:0]            rd_tid,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           next,
  output logic [$clog2(DEPTH):0]     depth,
  output logic [THREADS-1:0]         err,
  output logic                       op_ok
);

  localparam int AW  = $clog2(DEPTH);
  localparam int MAW = TIDW + AW;
  localparam int TOT = THREADS * DEPTH;

  typedef logic [AW:0] cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_REPL = 3'd3,
    OP_DUP  = 3'd4,
    OP_GET  = 3'd5,
    OP_PUT  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  logic [WIDTH-1:0]   mem_q [TOT];
  cnt_t               depth_q [THREADS];
  cnt_t               depth_d [THREADS];
  logic [THREADS-1:0] err_q, err_d;
  logic               op_ok_q, op_ok_d;

  logic               wr_en;
  logic [MAW-1:0]     wr_addr;
  logic [WIDTH-1:0]   wr_data;

  // Read side: thread id out of range reads as an empty stack.
  logic               rd_hit;
  logic [TIDW-1:0]    rd_sel;
  cnt_t               rd_depth;
  logic [AW-1:0]      top_idx, next_idx;

  always_comb begin
    rd_hit   = int'(rd_tid) < THREADS;
    rd_sel   = rd_hit ? rd_tid : '0;
    rd_depth = rd_hit ? depth_q[rd_sel] : '0;
    top_idx  = rd_depth[AW-1:0] - AW'(1);
    next_idx = rd_depth[AW-1:0] - AW'(2);
    top      = (rd_depth >= cnt_t'(1)) ? mem_q[{rd_sel, top_idx}]  : '0;
    next     = (rd_depth >= cnt_t'(2)) ? mem_q[{rd_sel, next_idx}] : '0;
  end

  // Op side
  logic               tid_ok, ok;
  logic [TIDW-1:0]    op_sel;
  cnt_t               d, d_new, off_c;
  logic [AW-1:0]      wr_idx, dm1_idx, src_idx;
  op_e                op_cur;

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    op_ok_d = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = wdata;
    ok      = 1'b1;
    op_cur  = op_e'(op);
    tid_ok  = int'(op_tid) < THREADS;
    op_sel  = tid_ok ? op_tid : '0;
    d       = depth_q[op_sel];
    d_new   = d;
    off_c   = {1'b0, op_off};
    dm1_idx = d[AW-1:0] - AW'(1);
    src_idx = d[AW-1:0] - AW'(1) - op_off;

    case (op_cur)
      OP_PUSH: if (d < FULL) begin
        wr_en = 1'b1; wr_idx = d[AW-1:0]; d_new = d + cnt_t'(1);
      end else ok = 1'b0;
      OP_POP: if (d >= cnt_t'(1)) d_new = d - cnt_t'(1);
              else ok = 1'b0;
      OP_REPL: if (d >= cnt_t'(2)) begin
        wr_en = 1'b1; wr_idx = d[AW-1:0] - AW'(2); d_new = d - cnt_t'(1);
      end else ok = 1'b0;
      OP_DUP: if (d >= cnt_t'(1) && d < FULL) begin
        wr_en = 1'b1; wr_idx = d[AW-1:0]; wr_data = mem_q[{op_sel, dm1_idx}];
        d_new = d + cnt_t'(1);
      end else ok = 1'b0;
      OP_GET: if (off_c < d && d < FULL) begin
        wr_en = 1'b1; wr_idx = d[AW-1:0]; wr_data = mem_q[{op_sel, src_idx}];
        d_new = d + cnt_t'(1);
      end else ok = 1'b0;
      OP_PUT: if (off_c < d) begin
        wr_en = 1'b1; wr_idx = src_idx;
      end else ok = 1'b0;
      default: ;
    endcase

    if (op_valid && tid_ok) begin
      if (ok) begin
        depth_d[op_sel] = d_new;
        op_ok_d         = 1'b1;
      end else begin
        err_d[op_sel]   = 1'b1;
      end
    end

    // Reset wins over a same-cycle op, including its storage write.
    wr_en   = wr_en & ok & op_valid & tid_ok & ~reset;
    wr_addr = {op_sel, wr_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < THREADS; i++) depth_q[i] <= '0;
      err_q   <= '0;
      op_ok_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
      op_ok_q <= op_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign depth = rd_depth;
  assign err   = err_q;
  assign op_ok = op_ok_q;

endmodule
